// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: drives a ready-handshaked data memory, stalls the core and aligns/extends load data.
// Optional request watchdog is compiled in with MEM_TIMEOUT_WATCHDOG_EN.
module mem_access_sequencer #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              instr_valid,
  input  logic [5:0]        cuOP,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              misaligned,
  output logic              bus_err
);

  localparam int unsigned OP_W   = 6;
  localparam int unsigned DATA_W = 32;

  localparam logic [OP_W-1:0] OP_LB  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(17);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;

  logic              op_byte, op_half, op_word, op_store;
  logic              op_mem, op_aligned, go, op_q_load, timeout;
  logic [3:0]        be_n;
  logic [DATA_W-1:0] wdata_n, load_data;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;

  // Opcode decode into access size and direction
  always_comb begin
    op_byte  = 1'b0;
    op_half  = 1'b0;
    op_word  = 1'b0;
    op_store = 1'b0;
    case (cuOP)
      OP_LB, OP_LBU: op_byte = 1'b1;
      OP_LH, OP_LHU: op_half = 1'b1;
      OP_LW:         op_word = 1'b1;
      OP_SB: begin op_byte = 1'b1; op_store = 1'b1; end
      OP_SH: begin op_half = 1'b1; op_store = 1'b1; end
      OP_SW: begin op_word = 1'b1; op_store = 1'b1; end
      default: ;
    endcase
  end

  assign op_mem     = instr_valid & (op_byte | op_half | op_word);
  assign op_aligned = op_byte | (op_half & ~addr[0]) | (op_word & (addr[1:0] == 2'b00));
  assign go         = (state == IDLE) & op_mem & op_aligned;
  assign misaligned = (state == IDLE) & op_mem & ~op_aligned;
  assign stall      = go | (state == REQ);

  // Store lane steering: replicate narrow data so every enabled lane carries it
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = store_data;
    if (op_byte) begin
      be_n    = 4'b0001 << addr[1:0];
      wdata_n = {4{store_data[7:0]}};
    end else if (op_half) begin
      be_n    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_n = {2{store_data[15:0]}};
    end
  end

  // Load lane select and extension, using the offset captured at issue
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (op_q)
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'h0, lane_byte};
      OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_data = {16'h0, lane_half};
      default: ;
    endcase
  end

  assign op_q_load = (op_q >= OP_LB) && (op_q <= OP_LHU);

`ifdef MEM_TIMEOUT_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             bus_err_q;

  assign timeout = ~mem_ready & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;

  // Wait counter restarts whenever the FSM is outside REQ
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= (state == REQ) & timeout;
      if (state != REQ)
        wd_cnt <= '0;
      else if (!mem_ready)
        wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
  assign bus_err        = 1'b0;
`endif

  // Sequencer: issue, hold request until ready (or watchdog), then one write-back cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      op_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= REQ;
            op_q      <= cuOP;
            off_q     <= addr[1:0];
            rd_q      <= rd;
            mem_req   <= 1'b1;
            mem_we    <= op_store;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
          end
        end
        REQ: begin
          if (mem_ready || timeout) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (mem_ready && op_q_load) begin
              rf_we    <= (rd_q != 5'd0);
              rf_waddr <= rd_q;
              rf_wdata <= load_data;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          rf_we    <= 1'b0;
          rf_waddr <= '0;
          rf_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed vector table, reset/watchdog sequences, and random ops vs a model.
module tb_mem_access_sequencer;

  localparam int unsigned TO = 4;
`ifdef MEM_TIMEOUT_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        clk, n_rst, instr_valid, mem_ready;
  logic [5:0]  cuOP;
  logic [31:0] addr, store_data, mem_rdata;
  logic [4:0]  rd;
  logic        mem_req, mem_we, stall, rf_we, misaligned, bus_err;
  logic [31:0] mem_addr, mem_wdata, rf_wdata;
  logic [3:0]  mem_be;
  logic [4:0]  rf_waddr;

  int tests = 0;
  int fails = 0;

  mem_access_sequencer #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .instr_valid(instr_valid), .cuOP(cuOP), .addr(addr),
    .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    int unsigned wait_n;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    int unsigned req_cycles, stall_cycles, misal_cycles, rfwe_cycles, buserr_cycles;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    bit          stable_ok, quiet_ok, post_ok, done_ok;
  } res_t;

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [31:0] addr, sdata;
    logic [4:0]  rd;
    int unsigned wait_n;
    logic [31:0] rdata;
    int unsigned e_req, e_stall, e_misal, e_rfwe;
    logic        e_we;
    logic [31:0] e_maddr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rfdata;
  } vec_t;

  function automatic res_t blank();
    res_t r;
    r.req_cycles = 0; r.stall_cycles = 0; r.misal_cycles = 0; r.rfwe_cycles = 0; r.buserr_cycles = 0;
    r.we = 1'b0; r.maddr = '0; r.be = '0; r.wdata = '0; r.rf_waddr = '0; r.rf_wdata = '0;
    r.stable_ok = 1'b1; r.quiet_ok = 1'b1; r.post_ok = 1'b1; r.done_ok = 1'b1;
    return r;
  endfunction

  // Reference: what one instruction should look like on the bus and register port
  function automatic res_t model(input stim_t s);
    res_t        r;
    int unsigned size, off;
    logic [31:0] mask, lane;
    bit          store, signed_ld;
    r = blank();
    if (!s.valid || s.op < 6'd10 || s.op > 6'd17) return r;
    case (s.op)
      6'd10, 6'd13, 6'd15: size = 1;
      6'd11, 6'd14, 6'd16: size = 2;
      default:             size = 4;
    endcase
    off = s.addr % 4;
    if ((s.addr % size) != 0) begin
      r.misal_cycles = 1;
      return r;
    end
    store     = (s.op >= 6'd15);
    signed_ld = (s.op == 6'd10) || (s.op == 6'd11);
    mask      = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    r.we      = store;
    r.maddr   = s.addr & ~32'h3;
    r.be      = 4'(((32'h1 << size) - 32'h1) << off);
    r.wdata   = (s.sdata & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1);
    if (WD_ON && s.wait_n >= TO) begin
      r.req_cycles    = TO;
      r.stall_cycles  = TO + 1;
      r.buserr_cycles = 1;
      return r;
    end
    r.req_cycles   = s.wait_n + 1;
    r.stall_cycles = s.wait_n + 2;
    if (!store) begin
      lane = (s.rdata >> (8 * off)) & mask;
      if (signed_ld && (((lane >> (8 * size - 1)) & 32'h1) != 0)) lane = lane | ~mask;
      r.rf_wdata    = lane;
      r.rf_waddr    = s.rd;
      r.rfwe_cycles = (s.rd != 5'd0) ? 1 : 0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one instruction, act as the memory, and record what the DUT did until it retires
  task automatic run_op(input stim_t s, output res_t o);
    int unsigned req_seen;
    bit          done;
    o = blank();
    o.done_ok = 1'b0;
    req_seen  = 0;
    done      = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      instr_valid = s.valid; cuOP = s.op; addr = s.addr; store_data = s.sdata; rd = s.rd;
      mem_rdata   = s.rdata;
      mem_ready   = mem_req && (req_seen == s.wait_n);
      #2;
      if (mem_req) begin
        if (req_seen == 0) begin
          o.we = mem_we; o.maddr = mem_addr; o.be = mem_be; o.wdata = mem_wdata;
        end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {o.we, o.maddr, o.be, o.wdata}) begin
          o.stable_ok = 1'b0;
        end
        req_seen++;
      end
      if (stall)      o.stall_cycles++;
      if (misaligned) o.misal_cycles++;
      if (rf_we)      o.rfwe_cycles++;
      if (bus_err)    o.buserr_cycles++;
      if (!stall) begin
        done = 1'b1; o.done_ok = 1'b1; o.rf_wdata = rf_wdata; o.rf_waddr = rf_waddr;
      end else if (rf_we || rf_wdata != 32'h0) begin
        o.quiet_ok = 1'b0;
      end
    end
    o.req_cycles = req_seen;
    @(negedge clk);
    instr_valid = 1'b0; mem_ready = 1'b0;
    #2;
    if (mem_req || stall || rf_we || misaligned || bus_err || rf_wdata != 32'h0) o.post_ok = 1'b0;
  endtask

  task automatic compare_res(input string n, input res_t g, input res_t e);
    check({n, ".req_cycles"},   g.req_cycles,    e.req_cycles);
    check({n, ".stall_cycles"}, g.stall_cycles,  e.stall_cycles);
    check({n, ".misaligned"},   g.misal_cycles,  e.misal_cycles);
    check({n, ".rf_we_cycles"}, g.rfwe_cycles,   e.rfwe_cycles);
    check({n, ".bus_err"},      g.buserr_cycles, e.buserr_cycles);
    check({n, ".rf_wdata"},     g.rf_wdata,      e.rf_wdata);
    check({n, ".flags(stable,quiet,post,done)"},
          32'({g.stable_ok, g.quiet_ok, g.post_ok, g.done_ok}),
          32'({e.stable_ok, e.quiet_ok, e.post_ok, e.done_ok}));
    if (e.req_cycles > 0) begin
      check({n, ".mem_we"},   32'(g.we), 32'(e.we));
      check({n, ".mem_addr"}, g.maddr,   e.maddr);
      check({n, ".mem_be"},   32'(g.be), 32'(e.be));
    end
    if (e.we)              check({n, ".mem_wdata"}, g.wdata, e.wdata);
    if (e.rfwe_cycles > 0) check({n, ".rf_waddr"}, 32'(g.rf_waddr), 32'(e.rf_waddr));
  endtask

  vec_t  vecs [14];
  stim_t s;
  res_t  got, exp;

  initial begin
    vecs[0]  = '{1'b1, 6'd12, 32'h100, 32'h0,        5'd5,  2, 32'hDEADBEEF, 3, 4, 0, 1, 1'b0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 6'd10, 32'h203, 32'h0,        5'd3,  0, 32'h80123456, 1, 2, 0, 1, 1'b0, 32'h200, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 6'd13, 32'h203, 32'h0,        5'd3,  0, 32'h80123456, 1, 2, 0, 1, 1'b0, 32'h200, 4'h8, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 6'd11, 32'h202, 32'h0,        5'd9,  1, 32'h80010000, 2, 3, 0, 1, 1'b0, 32'h200, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{1'b1, 6'd16, 32'h206, 32'h0000ABCD, 5'd0,  0, 32'h0,        1, 2, 0, 0, 1'b1, 32'h204, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[5]  = '{1'b1, 6'd12, 32'h102, 32'h0,        5'd5,  0, 32'h0,        0, 0, 1, 0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[6]  = '{1'b1, 6'd28, 32'h100, 32'h0,        5'd5,  0, 32'h0,        0, 0, 0, 0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 6'd12, 32'h040, 32'h0,        5'd0,  1, 32'h12345678, 2, 3, 0, 0, 1'b0, 32'h040, 4'hF, 32'h0,        32'h12345678};
    vecs[8]  = '{1'b1, 6'd14, 32'h0FE, 32'h0,        5'd17, 0, 32'hF00D1234, 1, 2, 0, 1, 1'b0, 32'h0FC, 4'hC, 32'h0,        32'h0000F00D};
    vecs[9]  = '{1'b1, 6'd15, 32'h301, 32'h123456A5, 5'd0,  1, 32'h0,        2, 3, 0, 0, 1'b1, 32'h300, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[10] = '{1'b1, 6'd17, 32'h3FC, 32'hCAFEF00D, 5'd0,  3, 32'h0,        4, 5, 0, 0, 1'b1, 32'h3FC, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{1'b1, 6'd11, 32'h203, 32'h0,        5'd2,  0, 32'h0,        0, 0, 1, 0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 6'd12, 32'h100, 32'h0,        5'd5,  0, 32'h0,        0, 0, 0, 0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 6'd10, 32'h200, 32'h0,        5'd31, 0, 32'h0000007F, 1, 2, 0, 1, 1'b0, 32'h200, 4'h1, 32'h0,        32'h0000007F};

    n_rst = 1'b0; instr_valid = 1'b0; cuOP = '0; addr = '0; store_data = '0; rd = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #2;
    check("reset.mem_req",   32'(mem_req), 32'h0);
    check("reset.mem_addr",  mem_addr,     32'h0);
    check("reset.mem_wdata", mem_wdata,    32'h0);
    check("reset.rf_wdata",  rf_wdata,     32'h0);
    check("reset.ctrl", 32'({mem_we, mem_be, stall, rf_we, rf_waddr, misaligned, bus_err}), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      s   = '{vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rd, vecs[i].wait_n, vecs[i].rdata};
      exp = blank();
      exp.req_cycles   = vecs[i].e_req;   exp.stall_cycles = vecs[i].e_stall;
      exp.misal_cycles = vecs[i].e_misal; exp.rfwe_cycles  = vecs[i].e_rfwe;
      exp.we = vecs[i].e_we; exp.maddr = vecs[i].e_maddr; exp.be = vecs[i].e_be;
      exp.wdata = vecs[i].e_wdata; exp.rf_wdata = vecs[i].e_rfdata; exp.rf_waddr = vecs[i].rd;
      run_op(s, got);
      compare_res($sformatf("vec%0d", i), got, exp);
    end

    // Reset pulled while the request is outstanding
    @(negedge clk);
    instr_valid = 1'b1; cuOP = 6'd12; addr = 32'h10; rd = 5'd7; mem_ready = 1'b0;
    @(negedge clk);
    #2;
    check("rst_mid.req_before", 32'(mem_req), 32'h1);
    instr_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    check("rst_mid.req_async", 32'(mem_req), 32'h0);
    check("rst_mid.stall",     32'(stall),   32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #2;
      check($sformatf("rst_mid.quiet%0d", i), 32'({mem_req, rf_we, stall}), 32'h0);
    end
    s = '{vecs[0].valid, vecs[0].op, vecs[0].addr, vecs[0].sdata, vecs[0].rd, vecs[0].wait_n, vecs[0].rdata};
    run_op(s, got);
    compare_res("rst_mid.after", got, model(s));

`ifdef MEM_TIMEOUT_WATCHDOG_EN
    // Memory never answers: abort after TO request cycles
    s   = '{1'b1, 6'd12, 32'h20, 32'h0, 5'd4, 99, 32'h55};
    exp = blank();
    exp.req_cycles = 4; exp.stall_cycles = 5; exp.buserr_cycles = 1;
    exp.maddr = 32'h20; exp.be = 4'hF;
    run_op(s, got);
    compare_res("watchdog", got, exp);
`endif

    for (int i = 0; i < 300; i++) begin
      int unsigned pick;
      pick     = $urandom_range(0, 9);
      s.valid  = ($urandom_range(0, 7) != 0);
      s.op     = (pick < 8) ? 6'(10 + pick) : 6'($urandom);
      s.addr   = $urandom;
      s.sdata  = $urandom;
      s.rd     = 5'($urandom);
      s.wait_n = $urandom_range(0, 3);
      s.rdata  = $urandom;
      run_op(s, got);
      compare_res($sformatf("rand%0d", i), got, model(s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
